// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-client RAM port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Arbiter states: idle (arbitration bubble) or owned by one client.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OWN0 = 2'b01,
    S_OWN1 = 2'b10
  } state_t;

  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

  // One in-flight read: whether the slot holds a read, and who issued it.
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client-side and RAM-side bundles of the RAM port arbiter.
// Latency: none (wiring only).
// Backpressure: client commands are held until req & gnt at a clock edge.
// Client bundle: req/we/addr/wdata in, gnt (combinational accept), rvalid/rdata out.
// RAM bundle: wr_en/wr_addr/data_in and rd_en/rd_addr toward the RAM, data_out back.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = ram_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DEF_DATA_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface ram_port_arbiter_ram_if #(
  parameter int ADDR_W = ram_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DEF_DATA_W
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] data_out;

  modport master (output wr_en, wr_addr, data_in, rd_en, rd_addr, input data_out);
  modport slave  (input wr_en, wr_addr, data_in, rd_en, rd_addr, output data_out);
endinterface

// File: rtl/ram_arb_rd_tag.sv
// Tracks issued reads until their RAM data returns and steers it to the issuing client.
// Latency: rvalid/rdata registered one clock after RAM data_out is valid.
// Backpressure: none; every tracked read produces exactly one rvalid pulse.
// Ports: clk, rst; iss_vld/iss_id (read on the RAM port this cycle, issuer);
//        ram_dout (RAM read data); rvalid0/1 + rdata0/1 per-client returns.
module ram_arb_rd_tag
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_vld,
  input  logic              iss_id,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  // Slot 0 holds the read the RAM samples at this edge; slot RD_LAT holds the
  // read whose data is on ram_dout during the current cycle.
  rd_tag_t tag_sr [RD_LAT+1];
  rd_tag_t head;
  logic    hit0;
  logic    hit1;

  assign head = tag_sr[RD_LAT];
  assign hit0 = head.vld & (head.id == CLI0);
  assign hit1 = head.vld & (head.id == CLI1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) tag_sr[i] <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      tag_sr[0] <= '{vld: iss_vld, id: iss_id};
      for (int i = 1; i <= RD_LAT; i++) tag_sr[i] <= tag_sr[i-1];
      rvalid0 <= hit0;
      rvalid1 <= hit1;
      if (hit0) rdata0 <= ram_dout;
      if (hit1) rdata1 <= ram_dout;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM (separate write/read ports) between two clients.
// Latency: command reaches the RAM one clock after accept; read data returns RD_LAT+2 clocks after accept.
// Backpressure: gnt is combinational; a client holds its command until req & gnt at an edge.
// Ports: clk, rst (sync, active-high); cl0/cl1 client bundles (slave); ram bundle (master).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_port_arbiter_if.slave      cl0,
  ram_port_arbiter_if.slave      cl1,
  ram_port_arbiter_ram_if.master ram
);

  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BURST_MAX - 1);

  state_t           state;
  state_t           state_nxt;
  logic             last_owner;
  logic             last_owner_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nxt;

  logic gnt0;
  logic gnt1;
  logic acc0;
  logic acc1;
  logic acc;

  assign acc0 = cl0.req & gnt0;
  assign acc1 = cl1.req & gnt1;
  assign acc  = acc0 | acc1;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_owner <= CLI1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  // An owner gives up the grant when it stops requesting, or when it has
  // just completed BURST_MAX beats while the other client is waiting.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      S_IDLE: begin
        if (cl0.req && cl1.req) state_nxt = (last_owner == CLI1) ? S_OWN0 : S_OWN1;
        else if (cl0.req)       state_nxt = S_OWN0;
        else if (cl1.req)       state_nxt = S_OWN1;
      end
      S_OWN0: begin
        if (!cl0.req || (acc0 && beat_cnt == CNT_TOP && cl1.req)) begin
          last_owner_nxt = CLI0;
          beat_cnt_nxt   = '0;
          state_nxt      = cl1.req ? S_OWN1 : S_IDLE;
        end else if (acc0 && beat_cnt != CNT_TOP) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      S_OWN1: begin
        if (!cl1.req || (acc1 && beat_cnt == CNT_TOP && cl0.req)) begin
          last_owner_nxt = CLI1;
          beat_cnt_nxt   = '0;
          state_nxt      = cl0.req ? S_OWN0 : S_IDLE;
        end else if (acc1 && beat_cnt != CNT_TOP) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Grants are masked while reset is asserted so nothing transfers in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        S_OWN0:  gnt0 = cl0.req;
        S_OWN1:  gnt1 = cl1.req;
        default: ;
      endcase
    end
  end

  assign cl0.gnt = gnt0;
  assign cl1.gnt = gnt1;

  // ---------------- Issue registers ----------------
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign sel_we    = acc1 ? cl1.we    : cl0.we;
  assign sel_addr  = acc1 ? cl1.addr  : cl0.addr;
  assign sel_wdata = acc1 ? cl1.wdata : cl0.wdata;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] data_in_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_id_q;

  // At most one beat is accepted per cycle, so the two enables are exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      data_in_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_id_q   <= CLI0;
    end else begin
      wr_en_q <= acc & sel_we;
      rd_en_q <= acc & ~sel_we;
      if (acc && sel_we) begin
        wr_addr_q <= sel_addr;
        data_in_q <= sel_wdata;
      end
      if (acc && !sel_we) begin
        rd_addr_q <= sel_addr;
        rd_id_q   <= acc1 ? CLI1 : CLI0;
      end
    end
  end

  assign ram.wr_en   = wr_en_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.data_in = data_in_q;
  assign ram.rd_en   = rd_en_q;
  assign ram.rd_addr = rd_addr_q;

  // ---------------- Read return ----------------
  ram_arb_rd_tag #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_tag (
    .clk      (clk),
    .rst      (rst),
    .iss_vld  (rd_en_q),
    .iss_id   (rd_id_q),
    .ram_dout (ram.data_out),
    .rvalid0  (cl0.rvalid),
    .rvalid1  (cl1.rvalid),
    .rdata0   (cl0.rdata),
    .rdata1   (cl1.rdata)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed phases plus random traffic against a
// transaction-level model (grant tenure rules, memory array, read-return queue).
module tb_ram_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if     #(.ADDR_W(AW), .DATA_W(DW)) c0 ();
  ram_port_arbiter_if     #(.ADDR_W(AW), .DATA_W(DW)) c1 ();
  ram_port_arbiter_ram_if #(.ADDR_W(AW), .DATA_W(DW)) rif ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM), .RD_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .cl0 (c0),
    .cl1 (c1),
    .ram (rif)
  );

  // RAM: write commits at the edge; read sampled at an edge, data valid RL edges later.
  logic [7:0] ram_mem [256] = '{default: 8'h00};
  logic [7:0] rpipe   [RL+1];
  always @(posedge clk) begin
    if (rif.wr_en === 1'b1) ram_mem[rif.wr_addr] <= rif.data_in;
    rpipe[0] <= (rif.rd_en === 1'b1) ? ram_mem[rif.rd_addr] : 8'h00;
    for (int i = 1; i <= RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rif.data_out = rpipe[RL];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- stimulus queues ----------------
  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;
  cmd_t q0[$];
  cmd_t q1[$];
  bit   acc0_f = 0;
  bit   acc1_f = 0;

  task automatic push(input int cli, input bit we, input logic [7:0] a, input logic [7:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d;
    if (cli == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  // Each client presents the head of its queue and holds it until accepted.
  initial begin
    c0.req = 0; c0.we = 0; c0.addr = 0; c0.wdata = 0;
    c1.req = 0; c1.we = 0; c1.addr = 0; c1.wdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (acc0_f && q0.size() > 0) q0.delete(0);
      if (acc1_f && q1.size() > 0) q1.delete(0);
      acc0_f = 0;
      acc1_f = 0;
      c0.req = (q0.size() > 0);
      if (q0.size() > 0) begin c0.we = q0[0].we; c0.addr = q0[0].addr; c0.wdata = q0[0].data; end
      c1.req = (q1.size() > 0);
      if (q1.size() > 0) begin c1.we = q1[0].we; c1.addr = q1[0].addr; c1.wdata = q1[0].data; end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    int         cli;
    logic [7:0] data;
  } rexp_t;
  rexp_t      rq[$];
  logic [7:0] mmem [256] = '{default: 8'h00};
  int         own  = -1;   // current grant holder, -1 = nobody
  int         run  = 0;    // beats accepted in the current tenure
  int         last = 1;    // client that held the grant most recently
  bit         e_wen = 0, e_ren = 0;
  logic [7:0] e_waddr = 0, e_din = 0, e_raddr = 0;
  bit         started = 0;
  bit         rst_prev = 0;
  int         n_rd_acc = 0;
  int         n_rv0 = 0;
  logic [7:0] last_rd0 = 0;

  always @(negedge clk) begin
    bit         r0, r1, g0, g1, a0, a1, ev0, ev1, rme, roth;
    int         me;
    cmd_t       c;
    rexp_t      e;
    r0 = c0.req;
    r1 = c1.req;
    if (started) begin
      chk("wr_en", rif.wr_en, e_wen);
      chk("rd_en", rif.rd_en, e_ren);
      chk("wr_addr", rif.wr_addr, e_waddr);
      chk("data_in", rif.data_in, e_din);
      chk("rd_addr", rif.rd_addr, e_raddr);
      chk("en_excl", rif.wr_en & rif.rd_en, 0);
      ev0 = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].cli == 0);
      ev1 = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].cli == 1);
      chk("rvalid0", c0.rvalid, ev0);
      chk("rvalid1", c1.rvalid, ev1);
      if (ev0) chk("rdata0", c0.rdata, rq[0].data);
      if (ev1) chk("rdata1", c1.rdata, rq[0].data);
      if (ev0 || ev1) rq.delete(0);
      if (rst_prev) begin
        chk("rdata0_rst", c0.rdata, 0);
        chk("rdata1_rst", c1.rdata, 0);
      end
      if (c0.rvalid === 1'b1) begin n_rv0++; last_rd0 = c0.rdata; end
    end
    g0 = !rst && own == 0 && r0;
    g1 = !rst && own == 1 && r1;
    if (started) begin
      chk("gnt0", c0.gnt, g0);
      chk("gnt1", c1.gnt, g1);
    end
    acc0_f = (c0.req & c0.gnt) === 1'b1;
    acc1_f = (c1.req & c1.gnt) === 1'b1;
    a0 = g0;
    a1 = g1;
    if (rst) begin
      own = -1; run = 0; last = 1;
      e_wen = 0; e_ren = 0; e_waddr = 0; e_din = 0; e_raddr = 0;
      rq.delete();
      started = 1;
    end else begin
      e_wen = 0;
      e_ren = 0;
      if (a0 || a1) begin
        c.we   = a1 ? c1.we    : c0.we;
        c.addr = a1 ? c1.addr  : c0.addr;
        c.data = a1 ? c1.wdata : c0.wdata;
        if (c.we) begin
          mmem[c.addr] = c.data;
          e_wen = 1; e_waddr = c.addr; e_din = c.data;
        end else begin
          e_ren = 1; e_raddr = c.addr;
          e.due = cyc + RL + 3; e.cli = a1 ? 1 : 0; e.data = mmem[c.addr];
          rq.push_back(e);
          n_rd_acc++;
        end
      end
      if (own < 0) begin
        if (r0 && r1)  own = (last == 1) ? 0 : 1;
        else if (r0)   own = 0;
        else if (r1)   own = 1;
      end else begin
        me   = own;
        rme  = (me == 0) ? r0 : r1;
        roth = (me == 0) ? r1 : r0;
        if (rme) run++;
        if (!rme || (roth && run >= BM)) begin
          last = me;
          run  = 0;
          own  = roth ? 1 - me : -1;
        end
      end
    end
    rst_prev = rst;
  end

  task automatic drain();
    int t = 0;
    while ((q0.size() > 0 || q1.size() > 0 || rq.size() > 0) && t < 400) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    chk("drain_timeout", (t >= 400), 0);
  endtask

  initial begin
    int n, cnt, t;
    // Reset with both clients requesting.
    push(0, 1, 8'hF0, 8'h5A);
    push(1, 1, 8'hF1, 8'h5B);
    repeat (5) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rel_bubble_gnt0", c0.gnt, 0);
    @(negedge clk);
    chk("rel_first_gnt0", c0.gnt, 1);
    drain();

    // Single client: 16 writes then 16 reads.
    cnt = n_rv0;
    for (int i = 0; i < 16; i++) push(0, 1, 8'(i), 8'(i) ^ 8'hA5);
    for (int i = 0; i < 16; i++) push(0, 0, 8'(i), 8'h00);
    drain();
    chk("single_rv0_count", n_rv0 - cnt, 16);
    chk("single_last_rd0", last_rd0, 8'h0F ^ 8'hA5);

    // Contention: both clients stream writes.
    for (int i = 0; i < 12; i++) begin
      push(0, 1, 8'h90 + 8'(i), 8'(i) + 8'h30);
      push(1, 1, 8'hA0 + 8'(i), 8'(i) + 8'h60);
    end
    drain();

    // Interleaved reads from two clients.
    push(0, 1, 8'h10, 8'h11);
    push(1, 1, 8'h20, 8'h22);
    drain();
    for (int i = 0; i < 6; i++) begin
      push(0, 0, 8'h10, 8'h00);
      push(1, 0, 8'h20, 8'h00);
    end
    drain();

    // Read right after a write to the same address.
    push(0, 1, 8'h80, 8'h3C);
    push(0, 0, 8'h80, 8'h00);
    drain();
    chk("raw_rd0", last_rd0, 8'h3C);

    // Reset one cycle after a read accept drops the read.
    n   = n_rd_acc;
    cnt = n_rv0;
    t   = 0;
    push(0, 0, 8'h80, 8'h00);
    while (n_rd_acc == n && t < 50) begin @(posedge clk); t++; end
    chk("midrst_accept_seen", (t >= 50), 0);
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #2 rst = 0;
    repeat (6) @(posedge clk);
    chk("midrst_no_rvalid", n_rv0 - cnt, 0);
    push(0, 1, 8'hC0, 8'h01);
    push(1, 1, 8'hC1, 8'h02);
    drain();

    // Random traffic.
    repeat (500) begin
      @(posedge clk);
      #2;
      if (q0.size() < 3 && $urandom_range(0, 3) != 0)
        push(0, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom));
      if (q1.size() < 3 && $urandom_range(0, 2) != 0)
        push(1, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
